// File: rtl/crono_bcd_vga_pkg.sv
// Shared definitions for the crono_bcd_vga countdown timer: state encoding,
// BCD constants and the preset sanitiser used by every count field.
package crono_bcd_vga_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } crono_state_e;

  localparam int         NUM_FIELDS   = 3;  // [0]=seconds [1]=minutes [2]=hours
  localparam logic [7:0] BCD_59       = 8'h59;
  localparam logic [7:0] BCD_ZERO     = 8'h00;
  localparam logic [7:0] HORA_MAX_DEF = 8'h23;

  typedef logic [NUM_FIELDS-1:0][7:0] crono_time_t;

  // Illegal digits collapse to 59 first, then the field bound is applied.
  function automatic logic [7:0] bcd_sanitize(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] s;
    s = (v[7:4] > 4'd5 || v[3:0] > 4'd9) ? BCD_59 : v;
    return (s > max) ? max : s;
  endfunction

endpackage

// File: rtl/crono_bcd_vga_if.sv
// Control/preset inputs and BCD display outputs of the countdown timer.
interface crono_bcd_vga_if;
  logic       tick;
  logic       start;
  logic       stop;
  logic       load;
  logic [7:0] pre_seg;
  logic [7:0] pre_min;
  logic [7:0] pre_hora;
  logic [7:0] dseg;
  logic [7:0] dmin;
  logic [7:0] dhora;
  logic       EN;
  logic       running;
  logic       fin;

  modport master (
    output tick, start, stop, load, pre_seg, pre_min, pre_hora,
    input  dseg, dmin, dhora, EN, running, fin
  );

  modport slave (
    input  tick, start, stop, load, pre_seg, pre_min, pre_hora,
    output dseg, dmin, dhora, EN, running, fin
  );
endinterface

// File: rtl/crono_bcd_vga_bcd_down_cnt.sv
// Two-digit packed-BCD down-counter with sanitising load; wraps 00 -> MAX and
// flags the wrap on borrow_out so the next field up can decrement.
module bcd_down_cnt
  import crono_bcd_vga_pkg::*;
#(
  parameter logic [7:0] MAX = BCD_59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       dec,
  input  logic [7:0] load_val,
  output logic [7:0] val,
  output logic       borrow_out
);
  logic [7:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (load)
      val_d = bcd_sanitize(load_val, MAX);
    else if (dec) begin
      if (val_q == BCD_ZERO)       val_d = MAX;
      else if (val_q[3:0] == 4'd0) val_d = {val_q[7:4] - 4'd1, 4'd9};
      else                         val_d = {val_q[7:4], val_q[3:0] - 4'd1};
    end
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) val_q <= BCD_ZERO;
    else        val_q <= val_d;

  assign val        = val_q;
  assign borrow_out = dec & ~load & (val_q == BCD_ZERO);
endmodule

// File: rtl/crono_bcd_vga.sv
// Countdown chronometer core: HH:MM:SS in packed BCD, one decrement per tick.
// Build option CRONO_AUTORELOAD_EN: reload last preset on expiry, fin pulses.
module crono_bcd_vga
  import crono_bcd_vga_pkg::*;
#(
  parameter logic [7:0] HORA_MAX  = HORA_MAX_DEF,
  parameter int         TICK_SYNC = 1
) (
  input logic            clk,
  input logic            reset,
  crono_bcd_vga_if.slave bus
);
`ifdef CRONO_AUTORELOAD_EN
  localparam bit AUTO_RLD = 1'b1;
`else
  localparam bit AUTO_RLD = 1'b0;
`endif

  crono_state_e state_q, state_d;
  logic         en_q, run_q, fin_q, fin_d;
  logic         tick_p, go, ld, rld, dec;
  logic         cnt_zero, cnt_one;
  logic         brw_s, brw_m, unused_hr_borrow;
  crono_time_t  pre, cnt, ld_val;

  assign pre = {bus.pre_hora, bus.pre_min, bus.pre_seg};

  generate
    if (TICK_SYNC != 0) begin : g_tsync
      assign tick_p = bus.tick;
    end else begin : g_tedge
      logic tick_q;
      always_ff @(posedge clk or negedge reset)
        if (!reset) tick_q <= 1'b0;
        else        tick_q <= bus.tick;
      assign tick_p = bus.tick & ~tick_q;
    end
  endgenerate

`ifdef CRONO_AUTORELOAD_EN
  crono_time_t shadow_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset)  shadow_q <= '0;
    else if (ld) shadow_q <= pre;
  assign ld_val = rld ? shadow_q : pre;
`else
  assign ld_val = pre;
`endif

  bcd_down_cnt #(.MAX(BCD_59)) u_seg (
    .clk, .reset, .load(ld | rld), .dec(dec), .load_val(ld_val[0]),
    .val(cnt[0]), .borrow_out(brw_s)
  );
  bcd_down_cnt #(.MAX(BCD_59)) u_min (
    .clk, .reset, .load(ld | rld), .dec(brw_s), .load_val(ld_val[1]),
    .val(cnt[1]), .borrow_out(brw_m)
  );
  bcd_down_cnt #(.MAX(HORA_MAX)) u_hora (
    .clk, .reset, .load(ld | rld), .dec(brw_m), .load_val(ld_val[2]),
    .val(cnt[2]), .borrow_out(unused_hr_borrow)
  );

  assign cnt_zero = (cnt == crono_time_t'(24'h000000));
  assign cnt_one  = (cnt == crono_time_t'(24'h000001));
  assign go       = bus.start & ~bus.stop;

  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    rld     = 1'b0;
    dec     = 1'b0;
    fin_d   = 1'b0;
    unique case (state_q)
      IDLE, PAUSE: begin
        if (bus.load) begin
          ld      = 1'b1;
          state_d = IDLE;
        end else if (go) begin
          state_d = cnt_zero ? DONE : RUN;
          fin_d   = cnt_zero;
        end
      end
      RUN: begin
        // With auto-reload, zero is only ever seen here for the one cycle after expiry.
        if (AUTO_RLD && cnt_zero) rld = 1'b1;
        else if (tick_p) begin
          dec = 1'b1;
          if (cnt_one) begin
            if (AUTO_RLD) fin_d   = 1'b1;
            else          state_d = DONE;
          end
        end
        if (bus.stop && state_d == RUN) state_d = PAUSE;
      end
      DONE: begin
        if (bus.load) begin
          ld      = 1'b1;
          state_d = IDLE;
        end
      end
      default: ;
    endcase
    if (!AUTO_RLD) fin_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      run_q   <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= ld | rld | dec;
      run_q   <= (state_d == RUN);
      fin_q   <= fin_d;
    end

  assign bus.dseg    = cnt[0];
  assign bus.dmin    = cnt[1];
  assign bus.dhora   = cnt[2];
  assign bus.EN      = en_q;
  assign bus.running = run_q;
  assign bus.fin     = fin_q;
endmodule

// File: tb/tb_crono_bcd_vga.sv
// Directed bench for crono_bcd_vga: every EN strobe is checked against a
// queue of hand-computed HHMMSS values; status outputs are checked directly.
module tb_crono_bcd_vga;
  import crono_bcd_vga_pkg::*;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  int          vectors     = 0;
  int          miscompares = 0;
  logic [23:0] exp_q[$];

  crono_bcd_vga_if bus();

  crono_bcd_vga #(.HORA_MAX(8'h23), .TICK_SYNC(1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: each EN strobe must match the oldest expected value.
  always @(negedge clk) begin : mon
    logic [23:0] e;
    if (bus.EN === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_EN: got EN with %h%h%h expected no strobe",
                 bus.dhora, bus.dmin, bus.dseg);
      end else begin
        e = exp_q.pop_front();
        chk("EN_value", {8'h00, bus.dhora, bus.dmin, bus.dseg}, {8'h00, e});
      end
    end
  end

  task automatic step(input logic t, input logic s, input logic p, input logic l);
    @(negedge clk);
    bus.tick = t; bus.start = s; bus.stop = p; bus.load = l;
    @(negedge clk);
    bus.tick = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.load = 1'b0;
  endtask

  task automatic setpre(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    bus.pre_hora = h; bus.pre_min = m; bus.pre_seg = s;
  endtask

  function automatic logic [31:0] cur();
    return {8'h00, bus.dhora, bus.dmin, bus.dseg};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1);
  end

  initial begin
    bus.tick = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.load = 1'b0;
    setpre(8'h00, 8'h00, 8'h00);
    @(negedge clk); @(negedge clk);
    chk("reset_state", {5'd0, bus.dhora, bus.dmin, bus.dseg, bus.EN, bus.running, bus.fin}, 32'd0);
    reset = 1'b1;

    // 00:01:05 count-down across a minute borrow
    setpre(8'h00, 8'h01, 8'h05);
    exp_q.push_back(24'h000105);
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    chk("running_after_start", bus.running, 1);
    exp_q.push_back(24'h000104); exp_q.push_back(24'h000103);
    exp_q.push_back(24'h000102); exp_q.push_back(24'h000101);
    exp_q.push_back(24'h000100); exp_q.push_back(24'h000059);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
    chk("value_after_6_ticks", cur(), 32'h000059);
    chk("fin_while_running", bus.fin, 0);
    step(0, 0, 1, 0);
    chk("running_after_stop", bus.running, 0);

`ifdef CRONO_AUTORELOAD_EN
    setpre(8'h00, 8'h00, 8'h03);
    exp_q.push_back(24'h000003);
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    exp_q.push_back(24'h000002); exp_q.push_back(24'h000001);
    exp_q.push_back(24'h000000); exp_q.push_back(24'h000003);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    chk("ar_fin_pulse", {bus.fin, bus.running}, 2'b11);
    @(negedge clk);
    chk("ar_fin_cleared", {bus.fin, bus.running}, 2'b01);
    chk("ar_reloaded", cur(), 32'h000003);
    step(0, 0, 1, 0);
`else
    // Expiry: 00:00:02 reaches zero and then ignores ticks
    setpre(8'h00, 8'h00, 8'h02);
    exp_q.push_back(24'h000002);
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    exp_q.push_back(24'h000001); exp_q.push_back(24'h000000);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("fin_running_at_zero", {bus.fin, bus.running}, 2'b10);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("value_held_in_done", cur(), 32'h000000);
`endif

    // Sanitising load
    setpre(8'h30, 8'h61, 8'h7A);
    exp_q.push_back(24'h235959);
    step(0, 0, 0, 1);
    chk("sanitised_value", cur(), 32'h235959);
    chk("fin_after_load", bus.fin, 0);

    // tick+stop together, start+stop together, tick in PAUSE, load in RUN
    step(0, 1, 0, 0);
    exp_q.push_back(24'h235958);
    step(1, 0, 1, 0);
    chk("pause_after_tick_stop", bus.running, 0);
    step(0, 1, 1, 0);
    chk("start_stop_in_pause", bus.running, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("resume_from_pause", bus.running, 1);
    setpre(8'h00, 8'h00, 8'h10);
    step(0, 0, 0, 1);
    chk("load_ignored_in_run", cur(), 32'h235958);

    // load wins over start; start at zero goes straight to DONE without EN
    step(0, 0, 1, 0);
    setpre(8'h00, 8'h00, 8'h00);
    exp_q.push_back(24'h000000);
    step(0, 0, 0, 1);
    exp_q.push_back(24'h000000);
    step(0, 1, 0, 1);
    chk("load_beats_start", bus.running, 0);
    step(0, 1, 0, 0);
    chk("start_at_zero_done", {bus.fin, bus.running}, 2'b10);

    // Asynchronous reset mid-count
    setpre(8'h01, 8'h23, 8'h45);
    exp_q.push_back(24'h012345);
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    exp_q.push_back(24'h012344);
    step(1, 0, 0, 0);
    #3 reset = 1'b0;
    #1 chk("async_reset_clear", {5'd0, bus.dhora, bus.dmin, bus.dseg, bus.EN, bus.running, bus.fin}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step(1, 0, 0, 0);
    chk("idle_after_reset", {bus.fin, bus.running}, 2'b00);
    step(0, 1, 0, 0);
    chk("idle_accepts_start", {bus.fin, bus.running}, 2'b10);

    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/crono_bcd_vga.md
Name: crono_bcd_vga

Overview:
- Countdown chronometer (timer) core for the VGA stopwatch display path.
- Holds hours/minutes/seconds in packed BCD and decrements once per 1 Hz tick.
- Drives the BCD value buses plus the one-cycle write strobe consumed by the per-field display registers.
- Asserts `fin` when the count reaches 00:00:00.
- Sits between the tick generator / user-programming logic and the seconds/minutes/hours display registers.

Parameters:
- HORA_MAX, 8'h23: highest legal hour value, packed BCD; hours preset saturation bound.
- TICK_SYNC, 1: 1 = `tick` is already a clean one-cycle pulse; 0 = `tick` is a level and the block performs rising-edge detection internally.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset; all state cleared while low.
- tick  in  1  1 Hz timing strobe; one clk cycle wide when TICK_SYNC=1.
- start  in  1  one-cycle pulse; begin or resume counting.
- stop  in  1  one-cycle pulse; pause counting.
- load  in  1  one-cycle pulse; capture the preset values.
- pre_seg  in  8  preset seconds, packed BCD (tens[7:4], units[3:0]).
- pre_min  in  8  preset minutes, packed BCD.
- pre_hora  in  8  preset hours, packed BCD.
- dseg  out  8  current seconds, packed BCD.
- dmin  out  8  current minutes, packed BCD.
- dhora  out  8  current hours, packed BCD.
- EN  out  1  one-cycle write strobe; high the cycle after any count-register update (load or decrement).
- running  out  1  high while in RUN.
- fin  out  1  level; high in DONE.

Behaviour:
- Reset (reset=0, asynchronous): dseg=dmin=dhora=0, EN=0, running=0, fin=0, state=IDLE.
- All outputs are registered. EN is a registered pulse, high exactly one cycle and aligned with the new dseg/dmin/dhora values.
- States: IDLE, RUN, PAUSE, DONE.
  - IDLE: start with non-zero count -> RUN; start with count 00:00:00 -> DONE with fin=1 and no EN.
  - RUN: tick -> decrement by 1 s; stop -> PAUSE; count reaching 00:00:00 on a tick -> DONE.
  - PAUSE: start -> RUN (same zero check as IDLE); load -> IDLE.
  - DONE: load -> IDLE and fin=0; start ignored.
- load is accepted in IDLE, PAUSE and DONE; it is ignored in RUN.
- On accepted load, dseg/dmin/dhora take the sanitised presets at the next edge; EN=1 the following cycle.
- Sanitising rules, applied per field:
  - Any nibble above 9, or seconds/minutes tens nibble above 5 -> field saturates to 8'h59.
  - Hours value above HORA_MAX -> field saturates to HORA_MAX.
- Decrement: seconds units borrow from seconds tens; seconds 00 -> 59 with a borrow to minutes; minutes 00 -> 59 with a borrow to hours. Hours never wrap, because the zero check stops counting first.
- Latency: tick sampled at edge N -> new value at edge N+1 -> EN high during cycle N+1 to N+2.
- Simultaneous events:
  - start and stop in the same cycle: stop wins.
  - tick and stop in the same cycle in RUN: the decrement is applied, then PAUSE.
  - tick outside RUN: ignored.
  - load and start in the same cycle: load wins.
- Reaching zero: the tick from 00:00:01 produces 00:00:00 with EN pulsed; fin and state=DONE take effect at the same edge as the new value.
- Reset asserted mid-count: immediate clear; no EN is generated for the cleared value.

Optional Feature:
- Macro: CRONO_AUTORELOAD_EN.
- Defined: the last accepted preset is stored in shadow registers. On reaching 00:00:00 in RUN, the block reloads the shadow value at the next edge, stays in RUN and pulses EN. fin becomes a one-cycle pulse per expiry instead of a level, and DONE is only reachable through start with zero count.
- Not defined: no shadow registers; DONE and the level fin behave as described above.

Decomposition:
- Shared package/header crono_defs: the state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3), BCD constants (BCD_59=8'h59, BCD_ZERO=8'h00) and the default HORA_MAX.
- One natural sub-module, bcd_down_cnt: a two-digit packed-BCD down-counter with parameter MAX, inputs dec and load_val, outputs val and borrow_out. It contains the sanitiser and is instantiated three times, for seconds, minutes and hours.

Test Plan:
- Reset release, then load with pre 00:01:05 and start -> after 5 ticks dseg=8'h00, dmin=8'h01; the 6th tick gives dmin=8'h00, dseg=8'h59; each tick produces exactly one EN pulse aligned with the new value.
- Load 00:00:02, start, 2 ticks -> count 00:00:00, fin=1, running=0; further ticks -> no EN and no value change.
- Load pre_seg=8'h7A, pre_min=8'h61, pre_hora=8'h30 -> dseg=8'h59, dmin=8'h59, dhora=HORA_MAX (8'h23).
- In RUN, stop and tick in the same cycle -> one decrement, then PAUSE; start and stop together in PAUSE -> remains in PAUSE.
- Start with count 00:00:00 -> DONE, fin=1, EN never asserted; load during RUN -> ignored, value unchanged.
- reset driven low mid-count at 01:23:45 -> outputs 0 immediately (asynchronous), state IDLE; with CRONO_AUTORELOAD_EN, preset 00:00:03 expires and reloads to 00:00:03 with a one-cycle fin pulse while running stays 1.
